// File: rtl/gsu_regfile_pkg.sv
// gsu_regfile_pkg
//   Shared definitions for the GSU general-register file:
//   - default indices of the program counter, loop counter and loop target;
//   - merge_lanes(): byte-lane merge used by the write path.
//   merge_lanes works on a MAX_W-bit container. Callers zero-extend their
//   operands and truncate the result, so any DATA_W up to MAX_W can use it.
package gsu_regfile_pkg;

  localparam int DEF_PC_IDX   = 15;
  localparam int DEF_LCNT_IDX = 12;
  localparam int DEF_LADR_IDX = 13;

  localparam int MAX_W  = 64;
  localparam int MAX_BE = MAX_W / 8;

  // Returns old_word with every byte lane whose enable bit is set replaced
  // by the corresponding lane of new_word.
  function automatic logic [MAX_W-1:0] merge_lanes(
    input logic [MAX_W-1:0]  old_word,
    input logic [MAX_W-1:0]  new_word,
    input logic [MAX_BE-1:0] be
  );
    logic [MAX_W-1:0] res;
    res = old_word;
    for (int i = 0; i < MAX_BE; i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/gsu_regfile_multiport_if.sv
// gsu_regfile_multiport_if
//   Bundles the write side (ALU Z bus), the read selects / read data
//   (operand buses) and the status outputs of the register file.
//   Signal protocol: there is no valid/ready pair. Every input is sampled
//   on every rising clk edge; a write happens when any wr_be bit is set,
//   an increment when pc_inc is set and a LOOP when loop_en is set.
//   rd_data, loop_taken and lcnt_zero are registered; pc is combinational.
//   master modport: the datapath driving the file.
//   slave  modport: the register file itself.
interface gsu_regfile_multiport_if
  import gsu_regfile_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREGS  = 16,
  parameter int NRD    = 2
);
  localparam int AW  = $clog2(NREGS);
  localparam int NBE = DATA_W / 8;

  logic [AW-1:0]         wr_sel;
  logic [NBE-1:0]        wr_be;
  logic [DATA_W-1:0]     wr_data;
  logic                  pc_inc;
  logic                  loop_en;
  logic [NRD*AW-1:0]     rd_sel;
  logic [NRD*DATA_W-1:0] rd_data;
  logic                  loop_taken;
  logic                  lcnt_zero;
  logic [DATA_W-1:0]     pc;

  modport master (
    output wr_sel, wr_be, wr_data, pc_inc, loop_en, rd_sel,
    input  rd_data, loop_taken, lcnt_zero, pc
  );

  modport slave (
    input  wr_sel, wr_be, wr_data, pc_inc, loop_en, rd_sel,
    output rd_data, loop_taken, lcnt_zero, pc
  );

endinterface

// File: rtl/gsu_regfile_read_port.sv
// gsu_regfile_read_port
//   One registered read port. It samples the next-state register array, so
//   a read that coincides with a write/increment/LOOP to the same register
//   returns the updated value one cycle later.
//   Ports:
//     clk, reset : clock, asynchronous active-high reset (clears data)
//     regs_nxt   : next-state value of every register
//     sel        : register index to read
//     data       : registered read data
module gsu_regfile_read_port
  import gsu_regfile_pkg::*;
#(
  parameter  int DATA_W = 16,
  parameter  int NREGS  = 16,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NREGS-1:0][DATA_W-1:0]  regs_nxt,
  input  logic [AW-1:0]                 sel,
  output logic [DATA_W-1:0]             data
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) data <= '0;
    else       data <= regs_nxt[sel];
  end

endmodule

// File: rtl/gsu_regfile_multiport.sv
// gsu_regfile_multiport
//   Parametrised GSU general-register file: NREGS x DATA_W flops with
//   byte-lane writes, NRD registered write-through read ports, program
//   counter auto-increment and a hardware LOOP decrement/branch.
//   Ports:
//     clk, reset : clock, asynchronous active-high reset (clears all state)
//     bus        : slave side of gsu_regfile_multiport_if
//                  (wr_sel/wr_be/wr_data, pc_inc, loop_en, rd_sel in;
//                   rd_data, loop_taken, lcnt_zero, pc out)
//   DATA_W must be a multiple of 8 and no wider than MAX_W.
module gsu_regfile_multiport
  import gsu_regfile_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int NREGS    = 16,
  parameter int NRD      = 2,
  parameter int PC_IDX   = NREGS - 1,
  parameter int LCNT_IDX = DEF_LCNT_IDX,
  parameter int LADR_IDX = DEF_LADR_IDX
) (
  input logic                     clk,
  input logic                     reset,
  gsu_regfile_multiport_if.slave  bus
);

  localparam int AW = $clog2(NREGS);

  typedef logic [NREGS-1:0][DATA_W-1:0] regs_t;

  regs_t             regs;
  regs_t             regs_nxt;
  logic [DATA_W-1:0] cnt_next;
  logic              branch;
  logic              loop_taken_q;
  logic              lcnt_zero_q;

  // Single next-state computation shared by storage and every read port.
  // Lower-priority sources are applied first; the byte write is merged on
  // top last, so it only overrides its enabled lanes.
  always_comb begin
    regs_nxt = regs;
    cnt_next = regs[LCNT_IDX] - DATA_W'(1);
    branch   = bus.loop_en && (cnt_next != '0);

    if (bus.loop_en) regs_nxt[LCNT_IDX] = cnt_next;

    // A taken branch replaces the increment rather than adding to it.
    if (branch)          regs_nxt[PC_IDX] = regs[LADR_IDX];
    else if (bus.pc_inc) regs_nxt[PC_IDX] = regs[PC_IDX] + DATA_W'(1);

    regs_nxt[bus.wr_sel] = DATA_W'(merge_lanes(MAX_W'(regs_nxt[bus.wr_sel]),
                                               MAX_W'(bus.wr_data),
                                               MAX_BE'(bus.wr_be)));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs         <= '0;
      loop_taken_q <= 1'b0;
      lcnt_zero_q  <= 1'b0;
    end else begin
      regs         <= regs_nxt;
      // Reflects the counter decrement even if a write overrode the counter.
      loop_taken_q <= branch;
      lcnt_zero_q  <= (regs_nxt[LCNT_IDX] == '0);
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    gsu_regfile_read_port #(
      .DATA_W (DATA_W),
      .NREGS  (NREGS)
    ) u_rd (
      .clk      (clk),
      .reset    (reset),
      .regs_nxt (regs_nxt),
      .sel      (bus.rd_sel[k*AW +: AW]),
      .data     (bus.rd_data[k*DATA_W +: DATA_W])
    );
  end

  assign bus.loop_taken = loop_taken_q;
  assign bus.lcnt_zero  = lcnt_zero_q;
  assign bus.pc         = regs[PC_IDX];

endmodule

// File: tb/tb_gsu_regfile_multiport.sv
// tb_gsu_regfile_multiport
//   Two instances run side by side from the same stimulus:
//     dut0 : DATA_W=16, NREGS=16, NRD=2, PC_IDX=15
//     dut1 : DATA_W=32, NREGS=32, NRD=3, PC_IDX=31
//   Narrower instance sees the low bits of each stimulus field.
module tb_gsu_regfile_multiport;
  import gsu_regfile_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  gsu_regfile_multiport_if #(.DATA_W(16), .NREGS(16), .NRD(2)) bus0 ();
  gsu_regfile_multiport_if #(.DATA_W(32), .NREGS(32), .NRD(3)) bus1 ();

  gsu_regfile_multiport #(.DATA_W(16), .NREGS(16), .NRD(2)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0)
  );

  gsu_regfile_multiport #(.DATA_W(32), .NREGS(32), .NRD(3), .PC_IDX(31)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  // ---------------- stimulus state ----------------
  logic [4:0]  s_sel;
  logic [3:0]  s_be;
  logic [31:0] s_data;
  logic        s_inc;
  logic        s_loop;
  logic [4:0]  s_rd [3];

  // ---------------- reference model ----------------
  // mem[c][r] holds register r of configuration c.
  logic [31:0] mem [2][32];
  int          cfg_w   [2] = '{16, 32};
  int          cfg_n   [2] = '{16, 32};
  int          cfg_pc  [2] = '{15, 31};
  int          cfg_nrd [2] = '{2, 3};
  logic [31:0] exp_q [$];

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] wmask(input int c);
    return (cfg_w[c] == 16) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
  endfunction

  task automatic clear_model();
    for (int c = 0; c < 2; c++)
      for (int r = 0; r < 32; r++) mem[c][r] = 32'h0;
    exp_q.delete();
  endtask

  // One clock edge of the specified behaviour for configuration c.
  task automatic model_step(input int c);
    logic [31:0] nxt [32];
    logic [31:0] cnt;
    logic        taken;
    int          sel;
    int          pcx;
    pcx = cfg_pc[c];
    sel = int'(s_sel) % cfg_n[c];
    for (int r = 0; r < 32; r++) nxt[r] = mem[c][r];
    cnt   = (mem[c][12] - 32'd1) & wmask(c);
    taken = s_loop && (cnt != 32'd0);
    if (s_loop) nxt[12] = cnt;
    if (taken)      nxt[pcx] = mem[c][13];
    else if (s_inc) nxt[pcx] = (mem[c][pcx] + 32'd1) & wmask(c);
    for (int i = 0; i < cfg_w[c] / 8; i++)
      if (s_be[i]) nxt[sel][8*i +: 8] = s_data[8*i +: 8];
    for (int r = 0; r < 32; r++) mem[c][r] = nxt[r];
    for (int k = 0; k < cfg_nrd[c]; k++)
      exp_q.push_back(nxt[int'(s_rd[k]) % cfg_n[c]]);
    exp_q.push_back(32'(taken));
    exp_q.push_back(32'(nxt[12] == 32'd0));
    exp_q.push_back(nxt[pcx]);
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    s_sel = '0; s_be = '0; s_data = '0; s_inc = 1'b0; s_loop = 1'b0;
    for (int k = 0; k < 3; k++) s_rd[k] = '0;
  endtask

  task automatic apply();
    bus0.wr_sel  = s_sel[3:0];
    bus0.wr_be   = s_be[1:0];
    bus0.wr_data = s_data[15:0];
    bus0.pc_inc  = s_inc;
    bus0.loop_en = s_loop;
    bus0.rd_sel  = {s_rd[1][3:0], s_rd[0][3:0]};
    bus1.wr_sel  = s_sel;
    bus1.wr_be   = s_be;
    bus1.wr_data = s_data;
    bus1.pc_inc  = s_inc;
    bus1.loop_en = s_loop;
    bus1.rd_sel  = {s_rd[2], s_rd[1], s_rd[0]};
  endtask

  function automatic logic [31:0] rd_obs(input int c, input int k);
    if (c == 0) return 32'(bus0.rd_data[k*16 +: 16]);
    return bus1.rd_data[k*32 +: 32];
  endfunction

  function automatic logic [31:0] pc_obs(input int c);
    return (c == 0) ? 32'(bus0.pc) : bus1.pc;
  endfunction

  function automatic logic [31:0] taken_obs(input int c);
    return (c == 0) ? 32'(bus0.loop_taken) : 32'(bus1.loop_taken);
  endfunction

  function automatic logic [31:0] zero_obs(input int c);
    return (c == 0) ? 32'(bus0.lcnt_zero) : 32'(bus1.lcnt_zero);
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check_cycle();
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k < cfg_nrd[c]; k++)
        check($sformatf("c%0d rd%0d", c, k), rd_obs(c, k), exp_q.pop_front());
      check($sformatf("c%0d loop_taken", c), taken_obs(c), exp_q.pop_front());
      check($sformatf("c%0d lcnt_zero", c),  zero_obs(c),  exp_q.pop_front());
      check($sformatf("c%0d pc", c),         pc_obs(c),    exp_q.pop_front());
    end
  endtask

  task automatic reset_checks(input string tag);
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k < cfg_nrd[c]; k++)
        check($sformatf("%s c%0d rd%0d", tag, c, k), rd_obs(c, k), 32'h0);
      check($sformatf("%s c%0d loop_taken", tag, c), taken_obs(c), 32'h0);
      check($sformatf("%s c%0d lcnt_zero", tag, c),  zero_obs(c),  32'h0);
      check($sformatf("%s c%0d pc", tag, c),         pc_obs(c),    32'h0);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    apply();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    check_cycle();
  endtask

  // Releases reset at a falling edge and checks the first edge after it.
  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
    apply();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    check_cycle();
  endtask

  task automatic wr(input logic [4:0] sel, input logic [3:0] be, input logic [31:0] data);
    set_idle();
    s_sel = sel; s_be = be; s_data = data;
  endtask

  // ---------------- test sequence ----------------
  int r;

  initial begin
    reset = 1'b1;
    set_idle();
    apply();
    clear_model();
    @(posedge clk);
    #1;
    reset_checks("por");
    release_reset();
    check("por lcnt_zero c0", zero_obs(0), 32'h1);
    check("por lcnt_zero c1", zero_obs(1), 32'h1);

    // Reset mid-cycle while a write to r3 is still presented.
    wr(5'd3, 4'hF, 32'h0000_ABCD); s_rd[0] = 5'd3;
    cycle();
    check("r3 write c0", rd_obs(0, 0), 32'h0000_ABCD);
    #2;
    reset = 1'b1;
    #1;
    reset_checks("mid");
    clear_model();
    set_idle(); s_rd[0] = 5'd3;
    release_reset();
    check("r3 after reset c0", rd_obs(0, 0), 32'h0);
    check("r3 after reset c1", rd_obs(1, 0), 32'h0);

    // Byte lanes.
    wr(5'd5, 4'hF, 32'h0000_1234); cycle();
    wr(5'd5, 4'h1, 32'h0000_FF77); s_rd[0] = 5'd5; cycle();
    check("lane lo c0", rd_obs(0, 0), 32'h0000_1277);
    check("lane lo c1", rd_obs(1, 0), 32'h0000_1277);
    wr(5'd5, 4'h2, 32'h0000_99FF); s_rd[1] = 5'd5; cycle();
    check("lane hi c0", rd_obs(0, 1), 32'h0000_9977);
    check("lane hi c1", rd_obs(1, 1), 32'h0000_9977);

    // Write-through bypass to all ports.
    wr(5'd7, 4'hF, 32'h0000_5555);
    s_rd[0] = 5'd7; s_rd[1] = 5'd7; s_rd[2] = 5'd7;
    cycle();
    check("bypass p0 c0", rd_obs(0, 0), 32'h0000_5555);
    check("bypass p1 c0", rd_obs(0, 1), 32'h0000_5555);
    check("bypass p2 c1", rd_obs(1, 2), 32'h0000_5555);

    // PC wrap and write-over-increment (sel 31 is r15 on the narrow file).
    wr(5'd31, 4'hF, 32'hFFFF_FFFF); cycle();
    set_idle(); s_inc = 1'b1; cycle();
    check("pc wrap c0", pc_obs(0), 32'h0);
    check("pc wrap c1", pc_obs(1), 32'h0);
    wr(5'd31, 4'hF, 32'h8000_8000); s_inc = 1'b1; cycle();
    check("pc write wins c0", pc_obs(0), 32'h0000_8000);
    check("pc write wins c1", pc_obs(1), 32'h8000_8000);

    // LOOP.
    wr(5'd12, 4'hF, 32'd2);          cycle();
    wr(5'd13, 4'hF, 32'h0000_0400);  cycle();
    wr(5'd31, 4'hF, 32'h0000_0410);  cycle();
    set_idle(); s_loop = 1'b1; s_rd[0] = 5'd12; cycle();
    check("loop1 cnt c0",   rd_obs(0, 0),  32'd1);
    check("loop1 pc c0",    pc_obs(0),     32'h0000_0400);
    check("loop1 taken c1", taken_obs(1),  32'h1);
    set_idle(); s_loop = 1'b1; s_inc = 1'b1; s_rd[0] = 5'd12; cycle();
    check("loop2 cnt c1",   rd_obs(1, 0),  32'd0);
    check("loop2 pc c0",    pc_obs(0),     32'h0000_0401);
    check("loop2 pc c1",    pc_obs(1),     32'h0000_0401);
    check("loop2 taken c0", taken_obs(0),  32'h0);
    check("loop2 zero c0",  zero_obs(0),   32'h1);
    set_idle(); s_loop = 1'b1; s_rd[0] = 5'd12; cycle();
    check("loop3 cnt c0",   rd_obs(0, 0),  32'h0000_FFFF);
    check("loop3 cnt c1",   rd_obs(1, 0),  32'hFFFF_FFFF);
    check("loop3 taken c0", taken_obs(0),  32'h1);
    check("loop3 pc c1",    pc_obs(1),     32'h0000_0400);

    // Lane 2 only exists on the wide file; the narrow one sees be=00.
    wr(5'd9, 4'h4, 32'h12AB_3456); s_rd[2] = 5'd9; s_rd[1] = 5'd9; cycle();
    check("lane2 c1", rd_obs(1, 2), 32'h00AB_0000);
    check("be zero c0", rd_obs(0, 1), 32'h0);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      set_idle();
      r      = int'($urandom_range(0, 7));
      s_sel  = 5'($urandom_range(0, 31));
      s_be   = 4'($urandom_range(0, 15));
      s_data = $urandom;
      if (r == 0) begin
        s_sel = 5'd12; s_be = 4'hF; s_data = 32'($urandom_range(0, 3));
      end else if (r == 1) begin
        s_sel = 5'd13;
      end else if (r == 2) begin
        s_sel = 5'd31;
      end else if (r == 3) begin
        s_be = 4'h0;
      end
      s_inc  = ($urandom_range(0, 2) == 0);
      s_loop = ($urandom_range(0, 2) == 0);
      for (int k = 0; k < 3; k++) s_rd[k] = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) s_rd[0] = 5'd12;
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/gsu_regfile_multiport.md
# gsu_regfile_multiport

Parametrised general-register file for the GSU datapath. It is the next-generation replacement for the fixed 16×16 register block. Width, register count and read-port count are configurable. It adds byte-lane writes, registered read ports with write-through bypass, a program-counter auto-increment, and a hardware LOOP decrement/branch. It sits between the ALU result bus (write side) and the operand buses (read side).

## Interface
Parameters:
- DATA_W, 16, register width in bits; must be a multiple of 8.
- NREGS, 16, number of registers; power of two, 4..64.
- NRD, 2, number of independent read ports.
- PC_IDX, NREGS-1, index of the program-counter register.
- LCNT_IDX, 12, index of the loop-counter register.
- LADR_IDX, 13, index of the loop-target register.
- Derived: AW = log2(NREGS); NBE = DATA_W/8.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- wr_sel  in  AW  destination register index.
- wr_be  in  NBE  byte-lane write enables; all-ones is a full write, zero is no write.
- wr_data  in  DATA_W  write data (ALU Z bus).
- pc_inc  in  1  increment the register at PC_IDX by 1 this cycle.
- loop_en  in  1  execute LOOP this cycle.
- rd_sel  in  NRD*AW  read indices, port k at bits [k*AW +: AW].
- rd_data  out  NRD*DATA_W  registered read data, port k at [k*DATA_W +: DATA_W].
- loop_taken  out  1  registered; 1 if the LOOP in the previous cycle branched.
- lcnt_zero  out  1  registered; 1 when the loop counter holds 0.
- pc  out  DATA_W  direct, unregistered copy of register PC_IDX.

## Operation
- Storage: NREGS×DATA_W flops. Reset value is 0 for every register.
- Byte write: for each lane i with wr_be[i]=1, reg[wr_sel][8i+7:8i] <= wr_data[8i+7:8i]. Lanes that are not enabled hold their value.
- PC: if pc_inc=1, reg[PC_IDX] <= reg[PC_IDX]+1, modulo 2^DATA_W (wraps from all-ones to 0).
- LOOP, when loop_en=1:
  - cnt_next = reg[LCNT_IDX]-1, modulo 2^DATA_W.
  - reg[LCNT_IDX] <= cnt_next.
  - If cnt_next≠0: reg[PC_IDX] <= reg[LADR_IDX] and loop_taken <= 1.
  - Otherwise loop_taken <= 0.
  - Counter 0 underflows to all-ones and the branch is taken.
- loop_taken <= 0 in any cycle with loop_en=0.
- Per-register priority, highest first. A lower-priority source affects only the bytes not written by a higher one.
  1. Byte write to that register. Only the enabled lanes are overridden.
  2. For PC_IDX: LOOP branch load, then pc_inc. pc_inc is ignored when the branch is taken.
  3. For LCNT_IDX: LOOP decrement. It applies to non-written lanes using the full-word decremented value.
- loop_taken is computed from cnt_next even when a write overrides LCNT_IDX.
- Reads:
  - rd_data[k] <= next-state value of reg[rd_sel[k]], i.e. write-through.
  - A read issued in the same cycle as a write, increment or LOOP to that register returns the updated value.
  - Any number of ports may select the same register.
- lcnt_zero <= (next-state reg[LCNT_IDX] == 0).

## Timing
- All state updates occur on the clk rising edge.
- Read latency is 1 cycle: select at edge n, data valid after edge n+1. Selects change every cycle without stall.
- pc is combinational from the PC flops; it reflects the edge-updated value in the same cycle.
- Back-to-back LOOPs are legal. Each LOOP sees the counter left by the previous cycle.
- Reset asserted mid-operation immediately forces:
  - all registers to 0;
  - rd_data, loop_taken and lcnt_zero to 0 (lcnt_zero is forced to 0 even though the counter is 0);
  - an in-flight write or LOOP to be lost.
- First edge after reset release: normal operation; lcnt_zero becomes 1 if the counter is still 0.
- No handshakes: every input is sampled every cycle.

## Structure
- Shared package gsu_regfile_pkg holds:
  - default index constants (PC_IDX=15, LCNT_IDX=12, LADR_IDX=13);
  - the function merge_lanes(old, new, be) returning the byte-merged word.
- Sub-module gsu_regfile_read_port: takes the next-state array and one select, and holds the output register. It is instantiated NRD times via generate.
- Next-state logic lives in one combinational block, so bypass and storage share the same value.

## Test plan
- Reset: write 0xABCD to r3, assert reset mid-cycle → rd_data, pc, loop_taken all 0 immediately; r3 reads 0 after release.
- Byte lanes: r5=0x1234, then wr_be=01 with data 0xFF77 → r5=0x1277; wr_be=10 with data 0x99FF → 0x9977.
- Bypass: write 0x5555 to r7 with rd_sel0=7 on the same edge → rd_data0=0x5555 one cycle later; port 1 on r7 also reads 0x5555.
- PC: pc=0xFFFF, pc_inc → pc=0x0000. pc_inc together with a full write of 0x8000 to r15 → pc=0x8000.
- LOOP: r12=2, r13=0x0400, pc=0x0410.
  - LOOP → r12=1, pc=0x0400, loop_taken=1.
  - LOOP with pc_inc → r12=0, pc=0x0401, loop_taken=0, lcnt_zero=1.
  - LOOP at r12=0 → r12=0xFFFF, branch taken.
- Parameter sweep: DATA_W=32, NREGS=32, NRD=3; repeat the bypass and LOOP tests with PC_IDX=31 and 4-lane wr_be=0b0100.
